// File: rtl/pipelined_adder_tree_acc.sv
// pipelined_adder_tree_acc: pipelined signed adder tree reducing N_IN lanes per beat, with valid/ready flow control and optional first..last accumulator
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input beat handshake; in_ready is combinational from out_valid/out_ready
//   in_data               N_IN signed lanes, lane i = in_data[i*IN_WIDTH +: IN_WIDTH]
//   in_first/in_last      accumulation boundaries, only meaningful when acc_mode=1
//   acc_mode              1 = accumulate first..last beats, 0 = one result per beat
//   out_valid/out_ready   result handshake
//   out_sum               signed ACC_WIDTH result
module pipelined_adder_tree_acc #(
  parameter int N_IN = 16,
  parameter int IN_WIDTH = 32,
  parameter int ACC_WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN*IN_WIDTH-1:0]   in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       acc_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_sum
);
  localparam int L = $clog2(N_IN);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic adv;
  logic [L:1] v, f, l, m;
  logic signed [ACC_WIDTH-1:0] ext [N_IN];
  // Registered tree nodes, level k (1..L) stored at offset N_IN - (2*N_IN >> k); the root is tr[N_IN-2].
  logic signed [ACC_WIDTH-1:0] tr [N_IN-1];
  logic signed [ACC_WIDTH-1:0] acc, base, nsum;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar i = 0; i < N_IN; i++) begin : g_ext
    assign ext[i] = {{(ACC_WIDTH-IN_WIDTH){in_data[i*IN_WIDTH+IN_WIDTH-1]}}, in_data[i*IN_WIDTH +: IN_WIDTH]};
  end
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    for (genvar j = 0; j < (N_IN >> k); j++) begin : g_node
      localparam int O = N_IN - ((2*N_IN) >> k);
      logic signed [ACC_WIDTH-1:0] a, b, s;
      if (k == 1) begin : g_leaf
        assign a = ext[2*j];
        assign b = ext[2*j+1];
      end else begin : g_inner
        localparam int P = N_IN - ((4*N_IN) >> k);
        assign a = tr[P+2*j];
        assign b = tr[P+2*j+1];
      end
      // Data needs no reset: bubbles are tracked by the valid bits alone.
      always_ff @(posedge clk)
        if (adv) s <= a + b;
      assign tr[O+j] = s;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      f <= '0;
      l <= '0;
      m <= '0;
    end else if (adv) begin
      v[1] <= in_valid;
      f[1] <= in_first;
      l[1] <= in_last;
      m[1] <= acc_mode;
      for (int k = 2; k <= L; k++) begin
        v[k] <= v[k-1];
        f[k] <= f[k-1];
        l[k] <= l[k-1];
        m[k] <= m[k-1];
      end
    end
  // acc is always zero while IDLE, so a non-first beat in IDLE starts from zero.
  assign base = (f[L] || state == IDLE) ? '0 : acc;
  assign nsum = base + tr[N_IN-2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      acc <= '0;
      state <= IDLE;
    end else if (adv) begin
      out_valid <= v[L] && (!m[L] || l[L]);
      if (v[L] && !m[L]) out_sum <= tr[N_IN-2];
      if (v[L] && m[L]) begin
        acc <= l[L] ? '0 : nsum;
        state <= l[L] ? IDLE : ACCUM;
        if (l[L]) out_sum <= nsum;
      end
    end
endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// tb_pipelined_adder_tree_acc: directed self-checking bench for pipelined_adder_tree_acc
module tb_pipelined_adder_tree_acc;
  localparam int N = 16;
  localparam int W = 32;
  localparam int A = 48;
  logic clk = 0, rst_n = 0, in_valid = 0, in_first = 0, in_last = 0, acc_mode = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [N*W-1:0] in_data = '0;
  logic [A-1:0] out_sum;
  int n_checks = 0, n_fail = 0;
  logic [N*W-1:0] bd [16];
  bit bf [16], bl [16], bm [16];
  logic [A-1:0] res [$];
  int res_cyc [$];

  pipelined_adder_tree_acc #(.N_IN(N), .IN_WIDTH(W), .ACC_WIDTH(A)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .acc_mode(acc_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] x);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = x;
    return r;
  endfunction

  function automatic logic [N*W-1:0] lane0(input int x);
    logic [N*W-1:0] r;
    r = '0;
    r[W-1:0] = x;
    return r;
  endfunction

  function automatic logic [A-1:0] sx(input int x);
    return A'(x);
  endfunction

  task automatic set_beat(input int i, input logic [N*W-1:0] d, input bit fi, input bit la, input bit mo);
    bd[i] = d;
    bf[i] = fi;
    bl[i] = la;
    bm[i] = mo;
  endtask

  // Drives n beats on consecutive cycles (out_ready held 1) and records every result with its cycle index.
  task automatic run_beats(input int n, input int span);
    res.delete();
    res_cyc.delete();
    for (int c = 0; c < span; c++) begin
      @(negedge clk);
      in_valid = c < n;
      in_data = c < n ? bd[c] : '0;
      in_first = c < n ? bf[c] : 1'b0;
      in_last = c < n ? bl[c] : 1'b0;
      acc_mode = c < n ? bm[c] : 1'b0;
      #1;
      if (out_valid) begin
        res.push_back(out_sum);
        res_cyc.push_back(c);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %0h want 0", out_sum); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1;
  endtask

  task automatic test_single_beat;
    set_beat(0, fill(32'd1), 0, 0, 0);
    run_beats(1, 8);
    n_checks++;
    if (res.size() != 1) begin n_fail++; $display("FAIL ones_count: got %0d want 1", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(16)) begin n_fail++; $display("FAIL ones_sum: got %0h want %0h", res.size() ? res[0] : '0, sx(16)); end
    n_checks++;
    if (res.size() < 1 || res_cyc[0] != 5) begin n_fail++; $display("FAIL ones_latency: got %0d want 5", res.size() ? res_cyc[0] : -1); end
  endtask

  task automatic test_signed;
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(i);
    set_beat(0, fill(32'hFFFF_FFFF), 0, 0, 0);
    set_beat(1, d, 0, 0, 0);
    run_beats(2, 9);
    n_checks++;
    if (res.size() != 2) begin n_fail++; $display("FAIL signed_count: got %0d want 2", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(-16)) begin n_fail++; $display("FAIL signed_neg16: got %0h want %0h", res.size() ? res[0] : '0, sx(-16)); end
    n_checks++;
    if (res.size() < 2 || res[1] !== sx(120)) begin n_fail++; $display("FAIL signed_120: got %0h want %0h", res.size() > 1 ? res[1] : '0, sx(120)); end
    n_checks++;
    if (res.size() < 2 || res_cyc[1] != res_cyc[0] + 1) begin n_fail++; $display("FAIL signed_consecutive: got gap %0d want 1", res.size() > 1 ? res_cyc[1] - res_cyc[0] : -1); end
  endtask

  task automatic test_back_to_back;
    logic [A-1:0] got [$];
    logic [A-1:0] held;
    int k;
    k = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 7 && c <= 9);
      in_valid = k < 8;
      in_data = fill(W'(k + 1));
      in_first = 0;
      in_last = 0;
      acc_mode = 0;
      #1;
      if (c == 7) held = out_sum;
      if (c >= 7 && c <= 9) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== sx(48)) begin n_fail++; $display("FAIL stall_hold c%0d: got v=%b sum=%0h want v=1 sum=%0h", c, out_valid, out_sum, sx(48)); end
      end
      if (out_valid && out_ready) got.push_back(out_sum);
      if (in_valid && in_ready) k++;
    end
    in_valid = 0;
    out_ready = 1;
    n_checks++;
    if (got.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== sx(16 * (i + 1))) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0h want %0h", i, got[i], sx(16 * (i + 1))); end
    end
  endtask

  task automatic test_accumulate;
    set_beat(0, lane0(10), 1, 0, 1);
    set_beat(1, lane0(20), 0, 0, 1);
    set_beat(2, lane0(-5), 0, 1, 1);
    run_beats(3, 10);
    n_checks++;
    if (res.size() != 1) begin n_fail++; $display("FAIL acc_pulses: got %0d want 1", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(25)) begin n_fail++; $display("FAIL acc_sum: got %0h want %0h", res.size() ? res[0] : '0, sx(25)); end
    n_checks++;
    if (res.size() < 1 || res_cyc[0] != 7) begin n_fail++; $display("FAIL acc_latency: got %0d want 7", res.size() ? res_cyc[0] : -1); end
  endtask

  task automatic test_first_last;
    set_beat(0, lane0(7), 1, 1, 1);
    set_beat(1, lane0(3), 1, 0, 1);
    set_beat(2, lane0(4), 0, 0, 1);
    set_beat(3, lane0(50), 1, 0, 1);
    set_beat(4, lane0(6), 0, 1, 1);
    run_beats(5, 12);
    n_checks++;
    if (res.size() != 2) begin n_fail++; $display("FAIL restart_count: got %0d want 2", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(7)) begin n_fail++; $display("FAIL restart_single: got %0h want %0h", res.size() ? res[0] : '0, sx(7)); end
    n_checks++;
    if (res.size() < 2 || res[1] !== sx(56)) begin n_fail++; $display("FAIL restart_total: got %0h want %0h", res.size() > 1 ? res[1] : '0, sx(56)); end
  endtask

  task automatic test_mode_mix;
    set_beat(0, lane0(10), 1, 0, 1);
    set_beat(1, lane0(3), 1, 1, 0);
    set_beat(2, lane0(5), 0, 1, 1);
    run_beats(3, 10);
    n_checks++;
    if (res.size() != 2) begin n_fail++; $display("FAIL mix_count: got %0d want 2", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(3)) begin n_fail++; $display("FAIL mix_plain: got %0h want %0h", res.size() ? res[0] : '0, sx(3)); end
    n_checks++;
    if (res.size() < 2 || res[1] !== sx(15)) begin n_fail++; $display("FAIL mix_acc: got %0h want %0h", res.size() > 1 ? res[1] : '0, sx(15)); end
  endtask

  task automatic test_reset_mid;
    set_beat(0, lane0(9), 0, 0, 0);
    set_beat(1, lane0(100), 1, 0, 1);
    set_beat(2, lane0(11), 0, 0, 0);
    for (int i = 3; i < 6; i++) set_beat(i, lane0(1), 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = c < 6;
      in_data = c < 6 ? bd[c] : '0;
      in_first = c < 6 ? bf[c] : 1'b0;
      in_last = 0;
      acc_mode = c < 6 ? bm[c] : 1'b0;
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== sx(11)) begin n_fail++; $display("FAIL pre_reset_out: got v=%b sum=%0h want v=1 sum=%0h", out_valid, out_sum, sx(11)); end
    rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_sum !== '0) begin n_fail++; $display("FAIL async_reset_sum: got %0h want 0", out_sum); end
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_beats(0, 8);
    n_checks++;
    if (res.size() != 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d results want 0", res.size()); end
    set_beat(0, lane0(4), 1, 1, 1);
    set_beat(1, lane0(5), 0, 1, 1);
    run_beats(2, 9);
    n_checks++;
    if (res.size() != 2) begin n_fail++; $display("FAIL post_reset_count: got %0d want 2", res.size()); end
    n_checks++;
    if (res.size() < 1 || res[0] !== sx(4)) begin n_fail++; $display("FAIL post_reset_sum: got %0h want %0h", res.size() ? res[0] : '0, sx(4)); end
    n_checks++;
    if (res.size() < 2 || res[1] !== sx(5)) begin n_fail++; $display("FAIL post_reset_nofirst: got %0h want %0h", res.size() > 1 ? res[1] : '0, sx(5)); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_signed();
    test_back_to_back();
    test_accumulate();
    test_first_last();
    test_mode_mix();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
